// File: rtl/smag_addsub_pipe.sv
// smag_addsub_pipe
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready
// handshaking on both sides.
//   Stage 1: resolves effective operand signs (zero magnitude counts as +0),
//            orders the magnitudes larger/smaller and flags equality.
//   Stage 2: adds or subtracts the ordered magnitudes and forms the result
//            sign and the overflow flag. A zero result is always +0.
// Backpressure flows from out_ready to in_ready without bubbles, so at
// full throughput one result leaves every cycle.
module smag_addsub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             isfu,
    output logic             isover,
    output logic             busy
);

    // Magnitude width: everything below the sign bit.
    localparam int MW = WIDTH - 1;

    // ------------------------------------------------------------------
    // Pipeline occupancy and handshake
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic w_rdy1;
    logic w_rdy2;
    logic w_accept;
    logic w_adv2;

    // Stage readiness: a stage can load when it is empty or its current
    // entry is leaving this same cycle.
    always_comb begin
        w_rdy2   = !r_v2 || out_ready;
        w_rdy1   = !r_v1 || w_rdy2;
        w_accept = in_valid && w_rdy1;
        w_adv2   = r_v1 && w_rdy2;
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational: effective signs and magnitude ordering
    // ------------------------------------------------------------------
    logic [MW-1:0] w_mag_x;
    logic [MW-1:0] w_mag_y;
    logic          w_sgn_x;
    logic          w_sgn_y;
    logic          w_x_ge_y;
    logic [MW-1:0] w_mag_big;
    logic [MW-1:0] w_mag_small;
    logic          w_sgn_big;
    logic          w_sgn_small;
    logic          w_mag_eq;

    // Split operands, fold op into Y's sign, and put the larger magnitude first.
    // NOTE: every always_comb output gets a value on every path (here via
    // the if/else covering both cases); a path that leaves one unassigned
    // infers a latch.
    always_comb begin
        w_mag_x  = x[MW-1:0];
        w_mag_y  = y[MW-1:0];
        // A zero magnitude is +0 whatever its sign bit says.
        w_sgn_x  = x[WIDTH-1] & (|w_mag_x);
        w_sgn_y  = (y[WIDTH-1] ^ op) & (|w_mag_y);
        w_x_ge_y = (w_mag_x >= w_mag_y);
        w_mag_eq = (w_mag_x == w_mag_y);
        if (w_x_ge_y) begin
            w_mag_big   = w_mag_x;
            w_sgn_big   = w_sgn_x;
            w_mag_small = w_mag_y;
            w_sgn_small = w_sgn_y;
        end else begin
            w_mag_big   = w_mag_y;
            w_sgn_big   = w_sgn_y;
            w_mag_small = w_mag_x;
            w_sgn_small = w_sgn_x;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [MW-1:0] r1_mag_big;
    logic [MW-1:0] r1_mag_small;
    logic          r1_sgn_big;
    logic          r1_sgn_small;
    logic          r1_mag_eq;

    // Stage 1 valid: refilled from the input whenever the stage can load.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking '=' here would
    // make the result depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else if (w_rdy1) begin
            r_v1 <= in_valid;
        end
    end

    // Stage 1 payload: captured only when an operand set is accepted.
    // NOTE: payload registers are cleared on reset as well so that every
    // flop leaves reset in a known state; without the valid bit they are
    // never observed, but known values keep simulation free of X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_mag_big   <= '0;
            r1_mag_small <= '0;
            r1_sgn_big   <= 1'b0;
            r1_sgn_small <= 1'b0;
            r1_mag_eq    <= 1'b0;
        end else if (w_accept) begin
            r1_mag_big   <= w_mag_big;
            r1_mag_small <= w_mag_small;
            r1_sgn_big   <= w_sgn_big;
            r1_sgn_small <= w_sgn_small;
            r1_mag_eq    <= w_mag_eq;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: magnitude add/subtract and sign resolution
    // ------------------------------------------------------------------
    logic [MW:0]   w_sum;
    logic [MW-1:0] w_diff;
    logic          w_same_sgn;
    logic [MW-1:0] w_res_mag;
    logic          w_res_sgn;
    logic          w_res_over;

    // Same signs add magnitudes (carry = overflow); differing signs subtract
    // the smaller from the larger, which can never overflow.
    always_comb begin
        w_sum      = {1'b0, r1_mag_big} + {1'b0, r1_mag_small};
        w_diff     = r1_mag_big - r1_mag_small;
        w_same_sgn = (r1_sgn_big == r1_sgn_small);
        if (w_same_sgn) begin
            w_res_mag  = w_sum[MW-1:0];
            w_res_over = w_sum[MW];
        end else begin
            w_res_mag  = r1_mag_eq ? '0 : w_diff;
            w_res_over = 1'b0;
        end
        // The larger operand's sign is also the common sign when signs
        // match; a zero magnitude (including a wrapped overflow) is +0.
        w_res_sgn = r1_sgn_big & (|w_res_mag);
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (outputs)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_s;
    logic             r_isover;

    // Stage 2 valid: takes stage 1's entry when stage 2 can load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2 <= 1'b0;
        end else if (w_rdy2) begin
            r_v2 <= r_v1;
        end
    end

    // Stage 2 payload: held unchanged while a result waits for out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s      <= '0;
            r_isover <= 1'b0;
        end else if (w_adv2) begin
            r_s      <= {w_res_sgn, w_res_mag};
            r_isover <= w_res_over;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_rdy1;
    assign out_valid = r_v2;
    assign s         = r_s;
    assign isfu      = r_s[WIDTH-1];
    assign isover    = r_isover;
    assign busy      = r_v1 || r_v2;

endmodule

// File: doc/smag_addsub_pipe.md
SMAG_ADDSUB_PIPE -- requirements
Module: smag_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude; legal range WIDTH >= 2.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand set present on op/x/y.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-006 SHALL have port op  input  1  0 = x+y, 1 = x-y.
REQ-007 SHALL have port x  input  WIDTH  sign-magnitude operand X.
REQ-008 SHALL have port y  input  WIDTH  sign-magnitude operand Y.
REQ-009 SHALL have port out_valid  output  1  result present on s/isfu/isover.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port s  output  WIDTH  sign-magnitude result.
REQ-012 SHALL have port isfu  output  1  result negative (equals s[WIDTH-1]).
REQ-013 SHALL have port isover  output  1  magnitude overflow.
REQ-014 SHALL have port busy  output  1  any pipeline stage holds a valid entry.

Function
REQ-015 SHALL accept an operand set when in_valid && in_ready at a rising edge; otherwise op/x/y are ignored.
REQ-016 SHALL implement a two-stage pipeline: stage 1 registers effective signs, magnitudes ordered larger/smaller, and a magnitude-equal flag; stage 2 registers s/isfu/isover.
REQ-017 SHALL assert out_valid exactly 2 cycles after acceptance when out_ready was never low.
REQ-018 SHALL derive stage readiness as rdy2 = !v2 || out_ready and rdy1 = !v1 || rdy2, with in_ready = rdy1, giving one result per cycle at full throughput.
REQ-019 SHALL hold s/isfu/isover/out_valid stable while out_valid && !out_ready; no entry lost, duplicated or reordered.
REQ-020 SHALL form the effective Y sign as y[WIDTH-1] XOR op.
REQ-021 SHALL treat an operand with zero magnitude as +0 regardless of its sign bit.
REQ-022 SHALL, for equal effective signs, add magnitudes; result sign = common sign; isover = carry out of bit WIDTH-2; s magnitude = sum truncated to WIDTH-1 bits.
REQ-023 SHALL, for differing effective signs, subtract the smaller magnitude from the larger; result sign = sign of the larger-magnitude operand; isover = 0.
REQ-024 SHALL never output -0: zero result magnitude forces sign 0, including truncated overflow results.
REQ-025 SHALL drive isfu = s[WIDTH-1] whenever out_valid is high.
REQ-026 SHALL drive busy = v1 || v2.

Reset
REQ-027 SHALL, on rst high, immediately clear v1, v2, out_valid, busy, s, isfu, isover to 0, independent of clk.
REQ-028 SHALL discard all in-flight entries on reset mid-operation; no result for them appears after release.
REQ-029 SHALL drive in_ready = 1 while rst is high and in the first cycle after release, but accept no operand while rst is high.

Verification
REQ-030 SHALL pass: op=0, x=0x00000005, y=0x00000003, out_ready=1 -> 2 cycles later out_valid=1, s=0x00000008, isfu=0, isover=0.
REQ-031 SHALL pass: op=1, x=0x00000003, y=0x00000005 -> s=0x80000002, isfu=1, isover=0.
REQ-032 SHALL pass: op=0, x=0x7FFFFFFF, y=0x00000001 -> s=0x00000000, isover=1, isfu=0; and op=0, x=0xFFFFFFFF, y=0x80000001 -> s=0x00000000, isover=1, isfu=0 (no -0).
REQ-033 SHALL pass: op=1, x=0x80000004, y=0x80000004 -> s=0x00000000, isfu=0; op=0, x=0x80000000, y=0x00000000 -> s=0x00000000.
REQ-034 SHALL pass: three back-to-back sets (5+3, 3-5, 7+1) with out_ready low for 3 cycles -> in_ready drops once both stages full, s holds 0x00000008 stable, then results 0x00000008, 0x80000002, 0x00000008 emerge in order, none lost.
REQ-035 SHALL pass: accept one set, assert rst one cycle later for one cycle -> out_valid/busy drop to 0 immediately, no stale result after release, next accepted set completes normally in 2 cycles.
